// File: rtl/sample_packer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sample_packer_pkg
// Brief    : Mode encodings and mode predicates shared by the sample packer
//            and the test-pattern sources.
// Revision : 1.0 - initial release
// ============================================================================
package sample_packer_pkg;

  typedef logic [1:0] mode_t;

  localparam mode_t MODE_ADC_UNPACKED  = 2'd0;
  localparam mode_t MODE_ADC_PACKED    = 2'd1;
  localparam mode_t MODE_RAMP_UNPACKED = 2'd2;
  localparam mode_t MODE_RAMP_PACKED   = 2'd3;

  // Bit 0 of the mode selects bit-packing of the output stream.
  function automatic logic isPacked(input mode_t m);
    return m[0];
  endfunction

  // Bit 1 of the mode selects the internal ramp as the sample source.
  function automatic logic isRamp(input mode_t m);
    return m[1];
  endfunction

endpackage
`default_nettype wire

// File: rtl/test_ramp_generator.sv
`default_nettype none
// ============================================================================
// Module   : test_ramp_generator
// Brief    : Wrapping WIDTH-bit ramp counter advanced by STEP per enabled
//            cycle. A clear restarts the sequence at 0; a clear that arrives
//            together with enable means the 0 value is being consumed now,
//            so the counter lands on STEP.
// Revision : 1.0 - initial release
// ============================================================================
module test_ramp_generator #(
  parameter int WIDTH = 10,
  parameter int STEP  = 1
) (
  input  logic             clock,
  input  logic             nReset,
  input  logic             enable,
  input  logic             clear,
  output logic [WIDTH-1:0] value
);

  localparam logic [WIDTH-1:0] STEP_W = WIDTH'(STEP);

  logic [WIDTH-1:0] value_q;
  logic [WIDTH-1:0] value_d;

  // Next ramp value: restart on clear, otherwise advance when enabled.
  always_comb begin
    value_d = value_q;
    if (clear) begin
      value_d = enable ? STEP_W : '0;
    end else if (enable) begin
      value_d = value_q + STEP_W;
    end
  end

  // Ramp register, modulo 2^WIDTH by natural wrap.
  always_ff @(posedge clock or negedge nReset) begin
    if (!nReset) begin
      value_q <= '0;
    end else begin
      value_q <= value_d;
    end
  end

  assign value = value_q;

endmodule
`default_nettype wire

// File: rtl/sample_packer.sv
`default_nettype none
// ============================================================================
// Module   : sample_packer
// Brief    : Selects ADC or test-ramp samples and emits them either one per
//            output word or as a continuous LSB-first packed bit stream.
//            A mode change is deferred until no packed bits are outstanding.
// Revision : 1.0 - initial release
// ============================================================================
module sample_packer
  import sample_packer_pkg::*;
#(
  parameter  int ADC_WIDTH = 10,
  parameter  int OUT_WIDTH = 16,
  parameter  int RAMP_STEP = 1,
  localparam int CNT_W     = (OUT_WIDTH > 1) ? $clog2(OUT_WIDTH) : 1
) (
  input  logic                 clock,
  input  logic                 nReset,
  input  logic                 sampleValid,
  input  logic [ADC_WIDTH-1:0] adcData,
  input  logic [1:0]           mode,
  input  logic                 flush,
  output logic [OUT_WIDTH-1:0] dataOut,
  output logic                 dataValid,
  output logic [1:0]           activeMode,
  output logic [CNT_W-1:0]     bitCount
);

  // Largest live payload is OUT_WIDTH-1 held bits plus one new sample.
  localparam int               ACC_W   = OUT_WIDTH + ADC_WIDTH - 1;
  localparam int               N_W     = $clog2(OUT_WIDTH + ADC_WIDTH) + 1;
  localparam logic [N_W-1:0]   ADC_W_N = N_W'(ADC_WIDTH);
  localparam logic [N_W-1:0]   OUT_W_N = N_W'(OUT_WIDTH);

  logic [ACC_W-1:0]     acc_q,       acc_d;
  logic [CNT_W-1:0]     cnt_q,       cnt_d;
  mode_t                mode_q,      mode_d;
  logic [OUT_WIDTH-1:0] data_q,      data_d;
  logic                 valid_q,     valid_d;
  logic [OUT_WIDTH-1:0] pend_q,      pend_d;
  logic                 pendValid_q, pendValid_d;

  logic [ADC_WIDTH-1:0] w_ramp;
  logic [ADC_WIDTH-1:0] w_sample;
  logic                 w_rampStart;
  logic                 w_rampEn;
  logic [ACC_W-1:0]     w_combined;
  logic [N_W-1:0]       w_n;

  // Mode in effect this cycle: a request is only taken once the accumulator
  // and the pending word are both empty, so a word never mixes two modes.
  always_comb begin
    mode_d = mode_q;
    if ((cnt_q == '0) && !pendValid_q) begin
      mode_d = mode;
    end
  end

  // Entering a ramp mode restarts the ramp; the first sample is then 0.
  assign w_rampStart = isRamp(mode_d) && !isRamp(mode_q);
  assign w_rampEn    = sampleValid && isRamp(mode_d);

  test_ramp_generator #(
    .WIDTH (ADC_WIDTH),
    .STEP  (RAMP_STEP)
  ) u_ramp (
    .clock  (clock),
    .nReset (nReset),
    .enable (w_rampEn),
    .clear  (w_rampStart),
    .value  (w_ramp)
  );

  assign w_sample   = isRamp(mode_d) ? (w_rampStart ? '0 : w_ramp) : adcData;
  assign w_combined = acc_q | (ACC_W'(w_sample) << cnt_q);
  assign w_n        = N_W'(cnt_q) + ADC_W_N;

  // Pack / unpack datapath with flush and the one-entry pending word.
  always_comb begin
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    data_d      = data_q;
    valid_d     = 1'b0;
    pend_d      = pend_q;
    pendValid_d = 1'b0;

    // A pending flush word always owns the output slot; it only exists when
    // the accumulator was just emptied, so no packed word can compete.
    if (pendValid_q) begin
      data_d  = pend_q;
      valid_d = 1'b1;
    end

    if (isPacked(mode_d)) begin
      if (sampleValid) begin
        if (w_n >= OUT_W_N) begin
          data_d  = w_combined[OUT_WIDTH-1:0];
          valid_d = 1'b1;
          acc_d   = w_combined >> OUT_WIDTH;
          cnt_d   = CNT_W'(w_n - OUT_W_N);
        end else begin
          acc_d = w_combined;
          cnt_d = CNT_W'(w_n);
        end
      end
      // Flush acts on the post-sample residue; it waits a cycle if the
      // output slot is already taken.
      if (flush && (cnt_d != '0)) begin
        if (valid_d) begin
          pend_d      = acc_d[OUT_WIDTH-1:0];
          pendValid_d = 1'b1;
        end else begin
          data_d  = acc_d[OUT_WIDTH-1:0];
          valid_d = 1'b1;
        end
        acc_d = '0;
        cnt_d = '0;
      end
    end else if (sampleValid) begin
      data_d  = OUT_WIDTH'(w_sample);
      valid_d = 1'b1;
    end
  end

  // State and registered outputs; reset discards any partial word.
  always_ff @(posedge clock or negedge nReset) begin
    if (!nReset) begin
      acc_q       <= '0;
      cnt_q       <= '0;
      mode_q      <= MODE_ADC_UNPACKED;
      data_q      <= '0;
      valid_q     <= 1'b0;
      pend_q      <= '0;
      pendValid_q <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      mode_q      <= mode_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      pend_q      <= pend_d;
      pendValid_q <= pendValid_d;
    end
  end

  assign dataOut    = data_q;
  assign dataValid  = valid_q;
  assign activeMode = mode_q;
  assign bitCount   = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_sample_packer.sv
`default_nettype none
// ============================================================================
// Module   : tb_sample_packer
// Brief    : Self-checking bench for sample_packer at default parameters.
//            Reference model keeps the packed stream as a queue of bits.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sample_packer;

  localparam int ADCW = 10;
  localparam int OUTW = 16;
  localparam int STEP = 1;

  logic        clock;
  logic        nReset;
  logic        sampleValid;
  logic [9:0]  adcData;
  logic [1:0]  mode;
  logic        flush;
  logic [15:0] dataOut;
  logic        dataValid;
  logic [1:0]  activeMode;
  logic [3:0]  bitCount;

  sample_packer #(
    .ADC_WIDTH (ADCW),
    .OUT_WIDTH (OUTW),
    .RAMP_STEP (STEP)
  ) dut (
    .clock       (clock),
    .nReset      (nReset),
    .sampleValid (sampleValid),
    .adcData     (adcData),
    .mode        (mode),
    .flush       (flush),
    .dataOut     (dataOut),
    .dataValid   (dataValid),
    .activeMode  (activeMode),
    .bitCount    (bitCount)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;
  int words = 0;

  // ---------------- reference model ----------------
  bit          mbits[$];    // packed bits not yet emitted, oldest first
  logic [1:0]  mActive;
  int          mRamp;
  bit          mPend;
  logic [15:0] mPendWord;
  bit          mValid;
  logic [15:0] mData;

  task automatic model_reset();
    mbits.delete();
    mActive = 2'd0;
    mRamp   = 0;
    mPend   = 1'b0;
    mPendWord = 16'h0;
    mValid  = 1'b0;
    mData   = 16'h0;
  endtask

  task automatic model_step(input bit sv, input logic [1:0] md,
                            input logic [9:0] adc, input bit fl);
    logic [1:0]  eff;
    logic [9:0]  smp;
    logic [15:0] w;
    int          b;
    eff = (mbits.size() == 0 && !mPend) ? md : mActive;
    if (eff[1] && !mActive[1]) mRamp = 0;
    mValid = 1'b0;
    if (mPend) begin
      mData  = mPendWord;
      mValid = 1'b1;
      mPend  = 1'b0;
    end
    smp = eff[1] ? 10'(mRamp) : adc;
    if (sv && eff[1]) mRamp = (mRamp + STEP) % (1 << ADCW);
    if (eff[0]) begin
      if (sv) for (int i = 0; i < ADCW; i++) mbits.push_back(smp[i]);
      if (mbits.size() >= OUTW) begin
        w = 16'h0;
        for (int i = 0; i < OUTW; i++) w[i] = mbits.pop_front();
        mData  = w;
        mValid = 1'b1;
      end
      if (fl && mbits.size() > 0) begin
        w = 16'h0;
        b = 0;
        while (mbits.size() > 0) begin
          w[b] = mbits.pop_front();
          b++;
        end
        if (mValid) begin
          mPend     = 1'b1;
          mPendWord = w;
        end else begin
          mData  = w;
          mValid = 1'b1;
        end
      end
    end else if (sv) begin
      mData  = 16'(smp);
      mValid = 1'b1;
    end
    mActive = eff;
  endtask

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // One clock with the given inputs, then compare the DUT to the model.
  task automatic step(input bit sv, input logic [1:0] md, input logic [9:0] adc, input bit fl);
    sampleValid = sv;
    mode        = md;
    adcData     = adc;
    flush       = fl;
    @(posedge clock);
    #1;
    model_step(sv, md, adc, fl);
    if (dataValid === 1'b1) words++;
    check("model dataValid", 32'(dataValid), 32'(mValid));
    if (mValid) check("model dataOut", 32'(dataOut), 32'(mData));
    check("model activeMode", 32'(activeMode), 32'(mActive));
    check("model bitCount", 32'(bitCount), 32'(mbits.size()));
  endtask

  task automatic do_reset();
    nReset      = 1'b0;
    sampleValid = 1'b0;
    mode        = 2'd0;
    adcData     = 10'h0;
    flush       = 1'b0;
    @(negedge clock);
    @(negedge clock);
    model_reset();
    nReset = 1'b1;
  endtask

  typedef struct {
    bit          sv;
    logic [1:0]  md;
    logic [9:0]  adc;
    bit          fl;
    bit          eValid;
    logic [15:0] eData;
    logic [3:0]  eCnt;
    logic [1:0]  eMode;
  } vec_t;

  vec_t vecs[13];
  int   cnt;

  initial begin
    // Ramp-packed opening: samples 0,1,2,3 sit at bit offsets 0,10,20,30,
    // so word0 = 1<<10 and word1 = (2<<4)|(3<<14).
    vecs[0]  = '{1'b1, 2'd3, 10'h000, 1'b0, 1'b0, 16'h0000, 4'd10, 2'd3};
    vecs[1]  = '{1'b1, 2'd3, 10'h000, 1'b0, 1'b1, 16'h0400, 4'd4,  2'd3};
    vecs[2]  = '{1'b1, 2'd3, 10'h000, 1'b0, 1'b0, 16'h0000, 4'd14, 2'd3};
    vecs[3]  = '{1'b1, 2'd3, 10'h000, 1'b0, 1'b1, 16'hC020, 4'd8,  2'd3};
    vecs[4]  = '{1'b0, 2'd3, 10'h000, 1'b1, 1'b1, 16'h0000, 4'd0,  2'd3};
    // ADC packed, then 1 -> 0 requested at bitCount 4: deferred until flush.
    vecs[5]  = '{1'b1, 2'd1, 10'h3FF, 1'b0, 1'b0, 16'h0000, 4'd10, 2'd1};
    vecs[6]  = '{1'b1, 2'd0, 10'h3FF, 1'b0, 1'b1, 16'hFFFF, 4'd4,  2'd1};
    vecs[7]  = '{1'b0, 2'd0, 10'h000, 1'b0, 1'b0, 16'h0000, 4'd4,  2'd1};
    vecs[8]  = '{1'b0, 2'd0, 10'h000, 1'b1, 1'b1, 16'h000F, 4'd0,  2'd1};
    vecs[9]  = '{1'b1, 2'd0, 10'h155, 1'b0, 1'b1, 16'h0155, 4'd0,  2'd0};
    vecs[10] = '{1'b0, 2'd0, 10'h000, 1'b1, 1'b0, 16'h0000, 4'd0,  2'd0};
    vecs[11] = '{1'b1, 2'd2, 10'h2AA, 1'b0, 1'b1, 16'h0000, 4'd0,  2'd2};
    vecs[12] = '{1'b1, 2'd2, 10'h2AA, 1'b0, 1'b1, 16'h0001, 4'd0,  2'd2};

    // Reset state.
    nReset = 1'b0;
    sampleValid = 1'b0; mode = 2'd0; adcData = 10'h0; flush = 1'b0;
    #12;
    check("reset dataOut", 32'(dataOut), 32'h0);
    check("reset dataValid", 32'(dataValid), 32'h0);
    check("reset activeMode", 32'(activeMode), 32'h0);
    check("reset bitCount", 32'(bitCount), 32'h0);
    do_reset();

    // Table vectors.
    for (int i = 0; i < 13; i++) begin
      step(vecs[i].sv, vecs[i].md, vecs[i].adc, vecs[i].fl);
      check($sformatf("vec%0d dataValid", i), 32'(dataValid), 32'(vecs[i].eValid));
      if (vecs[i].eValid) check($sformatf("vec%0d dataOut", i), 32'(dataOut), 32'(vecs[i].eData));
      check($sformatf("vec%0d bitCount", i), 32'(bitCount), 32'(vecs[i].eCnt));
      check($sformatf("vec%0d activeMode", i), 32'(activeMode), 32'(vecs[i].eMode));
    end

    // Ramp unpacked through the 0x3FF -> 0x000 wrap.
    do_reset();
    for (int i = 0; i < 1026; i++) begin
      step(1'b1, 2'd2, 10'h0, 1'b0);
      check("ramp word valid", 32'(dataValid), 32'h1);
      check("ramp word", 32'(dataOut), 32'(i % 1024));
    end

    // 80 full-scale samples packed -> 50 words of 0xFFFF.
    do_reset();
    words = 0;
    for (int i = 0; i < 80; i++) begin
      step(1'b1, 2'd1, 10'h3FF, 1'b0);
      if (dataValid) check("pack80 word", 32'(dataOut), 32'hFFFF);
    end
    check("pack80 word count", 32'(words), 32'd50);
    check("pack80 bitCount", 32'(bitCount), 32'd0);

    // Three samples then flush: 0xFFFF then 14 bits padded to 0x3FFF.
    do_reset();
    for (int i = 0; i < 3; i++) step(1'b1, 2'd1, 10'h3FF, 1'b0);
    step(1'b0, 2'd1, 10'h0, 1'b1);
    check("flush3 valid", 32'(dataValid), 32'h1);
    check("flush3 word", 32'(dataOut), 32'h3FFF);
    check("flush3 bitCount", 32'(bitCount), 32'd0);

    // Flush together with the 2nd sample: full word now, residue next cycle.
    do_reset();
    step(1'b1, 2'd1, 10'h3FF, 1'b0);
    step(1'b1, 2'd1, 10'h3FF, 1'b1);
    check("flush2 first word", 32'(dataOut), 32'hFFFF);
    step(1'b0, 2'd1, 10'h0, 1'b0);
    check("flush2 pending valid", 32'(dataValid), 32'h1);
    check("flush2 pending word", 32'(dataOut), 32'h000F);
    check("flush2 bitCount", 32'(bitCount), 32'd0);

    // Flush on the 8th sample: exactly 5 words, no padded extra.
    do_reset();
    words = 0;
    for (int i = 0; i < 8; i++) step(1'b1, 2'd1, 10'($urandom), (i == 7));
    step(1'b0, 2'd1, 10'h0, 1'b0);
    step(1'b0, 2'd1, 10'h0, 1'b0);
    check("flush8 word count", 32'(words), 32'd5);

    // Asynchronous reset mid-word: outputs clear before any clock edge.
    do_reset();
    for (int i = 0; i < 3; i++) step(1'b1, 2'd1, 10'h3FF, 1'b0);
    #2;
    nReset = 1'b0;
    #1;
    check("async reset dataOut", 32'(dataOut), 32'h0);
    check("async reset bitCount", 32'(bitCount), 32'h0);
    check("async reset activeMode", 32'(activeMode), 32'h0);
    check("async reset dataValid", 32'(dataValid), 32'h0);
    @(negedge clock);
    model_reset();
    nReset = 1'b1;
    words = 0;
    for (int i = 0; i < 3; i++) step(1'b0, 2'd1, 10'h0, 1'b1);
    check("post reset residual words", 32'(words), 32'd0);

    // Randomised traffic with occasional mode changes.
    do_reset();
    cnt = 0;
    begin
      logic [1:0] rmode;
      rmode = 2'd1;
      for (int i = 0; i < 4000; i++) begin
        if ($urandom_range(0, 19) == 0) rmode = 2'($urandom_range(0, 3));
        step($urandom_range(0, 3) != 0, rmode, 10'($urandom), $urandom_range(0, 9) == 0);
        cnt++;
      end
    end
    check("random cycles run", 32'(cnt), 32'd4000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
